// File: rtl/sfx_mixer.sv
// N_CH-voice retriggerable clip player; voices summed with saturation per codec write.
// Optional per-voice volume shift enabled by defining SFX_MIXER_VOLUME_EN.
module sfx_mixer #(
  parameter int N_CH     = 4,
  parameter int SAMPLE_W = 24,
  parameter int ADDR_W   = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_CH-1:0]                   trig,
  input  logic [N_CH-1:0][ADDR_W-1:0]       ch_base,
  input  logic [N_CH-1:0][ADDR_W-1:0]       ch_len,
`ifdef SFX_MIXER_VOLUME_EN
  input  logic [N_CH-1:0][2:0]              ch_shift,
`endif
  output logic [ADDR_W-1:0]                 rom_addr,
  input  logic signed [SAMPLE_W-1:0]        rom_data,
  input  logic                              aud_write_ready,
  output logic                              aud_write,
  output logic [SAMPLE_W-1:0]               aud_write_d,
  output logic [N_CH-1:0]                   busy
);

  localparam int ACC_W = SAMPLE_W + $clog2(N_CH) + 1;
  localparam int IDX_W = $clog2(N_CH + 1);

  typedef enum logic [1:0] {IDLE, MIX, WRITE} state_t;

  state_t                      state, state_nx;
  logic [IDX_W-1:0]            idx;
  logic [N_CH-1:0]             active, pending;
  logic [N_CH-1:0][ADDR_W-1:0] pos;
  logic signed [ACC_W-1:0]     acc, acc_sum, term, ext;
  logic [ACC_W-SAMPLE_W:0]     hi;
  logic [SAMPLE_W-1:0]         sat;
  logic [ADDR_W-1:0]           addr_hold, addr_mux;
  logic                        go, last, addr_phase;

  assign go         = (state == IDLE) && aud_write_ready;
  assign last       = (state == MIX) && (idx == IDX_W'(N_CH));
  assign addr_phase = (state == MIX) && (idx < IDX_W'(N_CH));
  assign busy       = active;
  assign rom_addr   = addr_phase ? addr_mux : addr_hold;

  always_comb begin
    addr_mux = '0;
    term     = '0;
    ext      = {{(ACC_W-SAMPLE_W){rom_data[SAMPLE_W-1]}}, rom_data};
    for (int i = 0; i < N_CH; i++) begin
      if (idx == IDX_W'(i))
        addr_mux = ch_base[i] + pos[i];
      // rom_data now answers the address issued for voice i last cycle
      if ((state == MIX) && (idx == IDX_W'(i + 1)) && active[i]) begin
`ifdef SFX_MIXER_VOLUME_EN
        term = ext >>> ch_shift[i];
`else
        term = ext;
`endif
      end
    end
  end

  always_comb begin
    acc_sum = acc + term;
    hi      = acc_sum[ACC_W-1:SAMPLE_W-1];
    sat     = acc_sum[SAMPLE_W-1:0];
    if (!((&hi) || !(|hi)))
      sat = acc_sum[ACC_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                             : {1'b0, {(SAMPLE_W-1){1'b1}}};
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (aud_write_ready) state_nx = MIX;
      MIX:     if (last) state_nx = WRITE;
      WRITE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      active      <= '0;
      pending     <= '0;
      pos         <= '0;
      acc         <= '0;
      addr_hold   <= '0;
      aud_write   <= 1'b0;
      aud_write_d <= '0;
    end else begin
      aud_write <= 1'b0;
      pending   <= pending | trig;
      if (go) begin
        for (int i = 0; i < N_CH; i++)
          if (pending[i] && (ch_len[i] != '0)) begin
            active[i] <= 1'b1;
            pos[i]    <= '0;
          end
        pending <= trig;
        acc     <= '0;
        idx     <= '0;
      end
      if (state == MIX) begin
        acc <= acc_sum;
        if (addr_phase) addr_hold <= addr_mux;
        if (last) begin
          aud_write   <= 1'b1;
          aud_write_d <= sat;
        end else begin
          idx <= idx + 1'b1;
        end
      end
      if (state == WRITE) begin
        for (int i = 0; i < N_CH; i++)
          if (active[i]) begin
            if (pos[i] == ch_len[i] - 1'b1) active[i] <= 1'b0;
            else                            pos[i]    <= pos[i] + 1'b1;
          end
      end
    end
  end

endmodule
